// File: rtl/unidad_busqueda.sv
// rtl/unidad_busqueda.sv - instruction fetch unit with a 2-entry instruction buffer
// Optional FETCH_PERF_EN adds the fetch_stalls counter output.
module unidad_busqueda #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_stalls
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] req_addr, req_addr_next;
    logic [1:0]  count, count_next;
    logic [31:0] head_instr, head_pc;
    logic [31:0] tail_instr, tail_pc;
    logic        push, pop;
    logic [31:0] target_aligned;

    assign target_aligned = branch_target & ~32'h3;

    assign imem_req    = (state != IDLE);
    assign imem_addr   = req_addr;
    assign instr       = head_instr;
    assign opcode      = head_instr[31:26];
    assign pc_out      = head_pc;
    assign instr_valid = (count != 2'd0);

    // A redirect cancels both buffer movements in the same cycle.
    always_comb begin
        pop  = instr_valid && instr_ready && !branch_taken;
        push = (state == WAIT_ACK) && imem_ack && !branch_taken;

        count_next = count;
        if (branch_taken) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_addr_next = req_addr;

        case (state)
            IDLE: begin
                if (!branch_taken && (count < 2'd2)) begin
                    state_next    = WAIT_ACK;
                    req_addr_next = fetch_pc;
                end
            end
            WAIT_ACK: begin
                if (branch_taken) begin
                    state_next = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    if (count_next < 2'd2) begin
                        state_next    = WAIT_ACK;
                        req_addr_next = fetch_pc + 32'd4;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The address of an outstanding request stays on the bus; only the next fetch moves.
        if (branch_taken) begin
            fetch_pc_next = target_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= 2'd0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
            count    <= count_next;
        end
    end

    // Push lands in the head when the buffer is (or becomes) otherwise empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_instr <= 32'd0;
            head_pc    <= 32'd0;
            tail_instr <= 32'd0;
            tail_pc    <= 32'd0;
        end else if (push) begin
            if (count_next == 2'd1) begin
                head_instr <= imem_data;
                head_pc    <= req_addr;
            end else begin
                tail_instr <= imem_data;
                tail_pc    <= req_addr;
            end
        end else if (pop) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_stalls <= 16'd0;
        end else if (!instr_valid && (fetch_stalls != 16'hFFFF)) begin
            fetch_stalls <= fetch_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unidad_busqueda.sv
// tb/tb_unidad_busqueda.sv - scoreboard bench for unidad_busqueda
// Covers FETCH_PERF_EN when the macro is defined.
module tb_unidad_busqueda;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_w_n;
    logic        ack_allow;
    logic        ready;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] imem_addr, imem_data, instr, pc_out;
    logic        imem_req, imem_ack, instr_valid;
    logic [5:0]  opcode;

    logic [31:0] imem_addr_w, imem_data_w, instr_w, pc_out_w;
    logic        imem_req_w, imem_ack_w, instr_valid_w;
    logic [5:0]  opcode_w;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_stalls, fetch_stalls_w;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA400_0000;
    endfunction

    assign imem_ack    = imem_req && ack_allow;
    assign imem_data   = mem_word(imem_addr);
    assign imem_ack_w  = imem_req_w && ack_allow;
    assign imem_data_w = mem_word(imem_addr_w);

    unidad_busqueda u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(ready), .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef FETCH_PERF_EN
        , .fetch_stalls(fetch_stalls)
`endif
    );

    unidad_busqueda #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_w_n),
        .imem_addr(imem_addr_w), .imem_req(imem_req_w), .imem_ack(imem_ack_w), .imem_data(imem_data_w),
        .instr(instr_w), .opcode(opcode_w), .pc_out(pc_out_w), .instr_valid(instr_valid_w),
        .instr_ready(ready), .branch_taken(1'b0), .branch_target(32'd0)
`ifdef FETCH_PERF_EN
        , .fetch_stalls(fetch_stalls_w)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_main
        logic [31:0] e, w;
        if (rst_n && instr_valid && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got pc %h expected none", pc_out);
            end else begin
                e = exp_q.pop_front();
                w = mem_word(e);
                check("retire_pc", pc_out, e);
                check("retire_instr", instr, w);
                check("retire_opcode", 32'(opcode), 32'(w[31:26]));
            end
        end
    end

    always @(negedge clk) begin : mon_wrap
        logic [31:0] e;
        if (rst_w_n && instr_valid_w && ready) begin
            if (exp_w_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wrap_retire: got pc %h expected none", pc_out_w);
            end else begin
                e = exp_w_q.pop_front();
                check("wrap_pc", pc_out_w, e);
                check("wrap_instr", instr_w, mem_word(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input logic rdy, input logic ack);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        rst_w_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_stalls", 32'(fetch_stalls), 32'd0);
`endif
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        ready         = rdy;
        ack_allow     = ack;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic end_phase(input string name);
        tick();
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic bus(input string name, input logic req, input logic [31:0] addr);
        check({name, "_req"}, 32'(imem_req), 32'(req));
        if (req) check({name, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        rst_n = 1'b0; rst_w_n = 1'b0; ready = 1'b0; ack_allow = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0;

        // Streaming with ack tied high; wrap instance runs alongside.
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        exp_w_q = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        start_phase(1'b1, 1'b1);
        rst_w_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            bus("stream", 1'b1, 32'((k - 1) * 4));
            check("stream_valid", 32'(instr_valid), 32'(k >= 2));
            if (k == 2) check("wrap_fetch_addr", imem_addr_w, 32'h0);
            if (k == 9) ready = 1'b0;
        end
        end_phase("stream_drain");
        check("wrap_drain", 32'(exp_w_q.size()), 32'd0);

        // Decode stalled: buffer fills to two, requests stop.
        exp_q = '{32'h0, 32'h4, 32'h8};
        start_phase(1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            case (k)
                1:  begin bus("full", 1'b1, 32'h0); check("full_valid", 32'(instr_valid), 32'd0); end
                2:  begin bus("full", 1'b1, 32'h4); check("full_pc", pc_out, 32'h0); end
                13: begin bus("full", 1'b0, 32'h0); check("full_pc", pc_out, 32'h4); end
                14: begin bus("full", 1'b1, 32'h8); check("full_valid", 32'(instr_valid), 32'd0); end
                15: check("full_pc", pc_out, 32'h8);
                default: ;
            endcase
            if (k >= 3 && k <= 12) begin
                check("full_hold_req", 32'(imem_req), 32'd0);
                check("full_hold_pc", pc_out, 32'h0);
                check("full_hold_instr", instr, mem_word(32'h0));
            end
            if (k == 12) ready = 1'b1;
            if (k == 16) ready = 1'b0;
        end
        end_phase("full_drain");

        // Slow memory: request held for three cycles.
        exp_q = '{32'h0};
        start_phase(1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            bus("slow", 1'b1, 32'h0);
            check("slow_valid", 32'(instr_valid), 32'd0);
        end
        ack_allow = 1'b1;
        tick();
        check("slow_pc", pc_out, 32'h0);
        bus("slow", 1'b1, 32'h4);
        ack_allow = 1'b0;
        tick();
        check("slow_valid", 32'(instr_valid), 32'd0);
        bus("slow", 1'b1, 32'h4);
        check("slow_drain", 32'(exp_q.size()), 32'd0);

        // Redirect while a request is outstanding; that response must vanish.
        exp_q = '{32'h0, 32'h4, 32'h100};
        start_phase(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            case (k)
                1:  bus("drop", 1'b1, 32'h0);
                2:  begin bus("drop", 1'b1, 32'h4); check("drop_pc", pc_out, 32'h0); end
                3:  begin bus("drop", 1'b1, 32'h8); check("drop_pc", pc_out, 32'h4); ack_allow = 1'b0; end
                4:  begin bus("drop", 1'b1, 32'h8); branch_taken = 1'b1; branch_target = 32'h103; end
                5:  begin bus("drop", 1'b1, 32'h8); branch_taken = 1'b0; end
                6:  begin bus("drop", 1'b1, 32'h8); ack_allow = 1'b1; end
                7:  bus("drop", 1'b0, 32'h0);
                8:  bus("drop", 1'b1, 32'h100);
                9:  begin check("drop_pc", pc_out, 32'h100); ack_allow = 1'b0; end
                10: bus("drop", 1'b1, 32'h104);
                default: ;
            endcase
            if (k >= 4 && k <= 8) check("drop_valid", 32'(instr_valid), 32'd0);
        end
        end_phase("drop_drain");

        // Redirect on the same edge as an ack.
        exp_q = '{32'h40, 32'h44};
        start_phase(1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            case (k)
                1: bus("bra", 1'b1, 32'h0);
                2: begin check("bra_pc", pc_out, 32'h0); branch_taken = 1'b1; branch_target = 32'h40; end
                3: begin branch_taken = 1'b0; bus("bra", 1'b0, 32'h0);
                         check("bra_valid", 32'(instr_valid), 32'd0); end
                4: begin bus("bra", 1'b1, 32'h40); check("bra_valid", 32'(instr_valid), 32'd0); end
                5: begin bus("bra", 1'b1, 32'h44); check("bra_pc", pc_out, 32'h40); end
                6: begin bus("bra", 1'b0, 32'h0); check("bra_pc", pc_out, 32'h40); ready = 1'b1; end
                7: check("bra_pc", pc_out, 32'h44);
                8: begin bus("bra", 1'b1, 32'h48); check("bra_valid", 32'(instr_valid), 32'd0); ready = 1'b0; end
                default: ;
            endcase
        end
        end_phase("bra_drain");

`ifdef FETCH_PERF_EN
        exp_q.delete();
        start_phase(1'b1, 1'b0);
        tick(); tick(); tick();
        check("stalls_count", 32'(fetch_stalls), 32'd3);
        repeat (70000) tick();
        check("stalls_sat", 32'(fetch_stalls), 32'hFFFF);
        tick(); tick();
        check("stalls_hold", 32'(fetch_stalls), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
